// File: rtl/sm3_feed_pkg.sv
// Shared types and constants for the SM3 message feeder.
package sm3_feed_pkg;

  typedef enum logic [1:0] {
    S_ACC  = 2'd0,
    S_HASH = 2'd1,
    S_OUT  = 2'd2
  } feed_state_e;

  localparam int RES_WORDS = 8;

  // Valid-byte count -> contiguous MSB-first byte-enable mask.
  function automatic logic [3:0] byte_mask(input logic [2:0] n);
    case (n)
      3'd1:    byte_mask = 4'b1000;
      3'd2:    byte_mask = 4'b1100;
      3'd3:    byte_mask = 4'b1110;
      3'd4:    byte_mask = 4'b1111;
      default: byte_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/sm3_byte_packer.sv
// Packs bytes big-endian into 32-bit words; one-deep output register
// drives the core's message-input handshake.
module sm3_byte_packer
  import sm3_feed_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  byte_d,
  input  logic        byte_vld,
  input  logic        byte_lst,
  output logic        byte_rdy,
  output logic        byte_acc,
  output logic [31:0] msg_inpt_d,
  output logic [3:0]  msg_inpt_vld_byte,
  output logic        msg_inpt_vld,
  output logic        msg_inpt_lst,
  input  logic        msg_inpt_rdy,
  output logic        lst_hs
);

  logic [31:0] pack_data_q, pack_data_d;
  logic [2:0]  pack_cnt_q, pack_cnt_d;
  logic        pack_lst_q, pack_lst_d;
  logic        pack_done_q, pack_done_d;
  logic        last_seen_q, last_seen_d;
  logic [31:0] out_data_q, out_data_d;
  logic [3:0]  out_be_q, out_be_d;
  logic        out_vld_q, out_vld_d;
  logic        out_lst_q, out_lst_d;

  logic        hs, out_free, moved;
  logic [31:0] cur_data;
  logic [2:0]  cur_cnt;
  logic        cur_lst, cur_done;

  assign hs       = out_vld_q && msg_inpt_rdy;
  assign out_free = !out_vld_q || hs;
  assign byte_rdy = en && !last_seen_q && !(pack_done_q && !out_free);
  assign byte_acc = byte_vld && byte_rdy;
  assign lst_hs   = hs && out_lst_q;

  always_comb begin
    out_data_d = out_data_q;
    out_be_d   = out_be_q;
    out_lst_d  = out_lst_q;
    out_vld_d  = out_vld_q && !hs;
    cur_data   = pack_data_q;
    cur_cnt    = pack_cnt_q;
    cur_lst    = pack_lst_q;
    cur_done   = pack_done_q;
    moved      = 1'b0;

    // A word parked in the pack register takes the free slot first.
    if (pack_done_q && out_free) begin
      out_data_d = pack_data_q;
      out_be_d   = byte_mask(pack_cnt_q);
      out_lst_d  = pack_lst_q;
      out_vld_d  = 1'b1;
      cur_data   = '0;
      cur_cnt    = '0;
      cur_lst    = 1'b0;
      cur_done   = 1'b0;
      moved      = 1'b1;
    end

    if (byte_acc) begin
      case (cur_cnt[1:0])
        2'd0:    cur_data[31:24] = byte_d;
        2'd1:    cur_data[23:16] = byte_d;
        2'd2:    cur_data[15:8]  = byte_d;
        default: cur_data[7:0]   = byte_d;
      endcase
      cur_cnt  = cur_cnt + 3'd1;
      cur_lst  = byte_lst;
      cur_done = byte_lst || (cur_cnt == 3'd4);
    end

    if (cur_done && out_free && !moved) begin
      out_data_d = cur_data;
      out_be_d   = byte_mask(cur_cnt);
      out_lst_d  = cur_lst;
      out_vld_d  = 1'b1;
      cur_data   = '0;
      cur_cnt    = '0;
      cur_lst    = 1'b0;
      cur_done   = 1'b0;
    end

    pack_data_d = cur_data;
    pack_cnt_d  = cur_cnt;
    pack_lst_d  = cur_lst;
    pack_done_d = cur_done;

    last_seen_d = last_seen_q;
    if (byte_acc && byte_lst) last_seen_d = 1'b1;
    else if (lst_hs)          last_seen_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_data_q <= '0;
      pack_cnt_q  <= '0;
      pack_lst_q  <= 1'b0;
      pack_done_q <= 1'b0;
      last_seen_q <= 1'b0;
      out_data_q  <= '0;
      out_be_q    <= '0;
      out_vld_q   <= 1'b0;
      out_lst_q   <= 1'b0;
    end else begin
      pack_data_q <= pack_data_d;
      pack_cnt_q  <= pack_cnt_d;
      pack_lst_q  <= pack_lst_d;
      pack_done_q <= pack_done_d;
      last_seen_q <= last_seen_d;
      out_data_q  <= out_data_d;
      out_be_q    <= out_be_d;
      out_vld_q   <= out_vld_d;
      out_lst_q   <= out_lst_d;
    end
  end

  assign msg_inpt_d        = out_data_q;
  assign msg_inpt_vld_byte = out_be_q;
  assign msg_inpt_vld      = out_vld_q;
  assign msg_inpt_lst      = out_lst_q;

endmodule

// File: rtl/sm3_msg_feeder.sv
// SM3 message feeder: byte stream -> core message words, core digest -> 8-word result stream.
//   state  | meaning
//   S_ACC  | accepting message bytes, emitting packed words
//   S_HASH | last word delivered, waiting for the core's digest pulse
//   S_OUT  | returning digest words, MSW first
module sm3_msg_feeder
  import sm3_feed_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       byte_d,
  input  logic             byte_vld,
  input  logic             byte_lst,
  output logic             byte_rdy,
  output logic [31:0]      msg_inpt_d,
  output logic [3:0]       msg_inpt_vld_byte,
  output logic             msg_inpt_vld,
  output logic             msg_inpt_lst,
  input  logic             msg_inpt_rdy,
  input  logic [255:0]     cmprss_otpt_res,
  input  logic             cmprss_otpt_vld,
  output logic [31:0]      res_d,
  output logic             res_vld,
  output logic             res_lst,
  input  logic             res_rdy,
  output logic             busy,
  output logic [CNT_W-1:0] msg_byte_cnt,
  output logic             len_ovf
);

  localparam logic [2:0] LAST_IDX = 3'(RES_WORDS - 1);

  feed_state_e      state_q, state_d;
  logic             run_q;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [255:0]     res_q, res_d_nxt;
  logic [2:0]       res_idx_q, res_idx_d;
  logic             res_vld_q, res_vld_d;
  logic             res_lst_q, res_lst_d;
  logic             en, byte_acc, lst_hs, res_hs;

  // Byte intake stays closed for the first cycle after reset release.
  assign en     = run_q && (state_q == S_ACC);
  assign res_hs = res_vld_q && res_rdy;

  sm3_byte_packer u_packer (
    .clk               (clk),
    .rst_n             (rst_n),
    .en                (en),
    .byte_d            (byte_d),
    .byte_vld          (byte_vld),
    .byte_lst          (byte_lst),
    .byte_rdy          (byte_rdy),
    .byte_acc          (byte_acc),
    .msg_inpt_d        (msg_inpt_d),
    .msg_inpt_vld_byte (msg_inpt_vld_byte),
    .msg_inpt_vld      (msg_inpt_vld),
    .msg_inpt_lst      (msg_inpt_lst),
    .msg_inpt_rdy      (msg_inpt_rdy),
    .lst_hs            (lst_hs)
  );

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    res_d_nxt = res_q;
    res_idx_d = res_idx_q;
    res_vld_d = res_vld_q;

    if (byte_acc) begin
      busy_d = 1'b1;
      if (!busy_q) ovf_d = 1'b0;
      if (&cnt_q) ovf_d = 1'b1;
      else        cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_ACC: if (lst_hs) state_d = S_HASH;
      S_HASH: begin
        if (cmprss_otpt_vld) begin
          res_d_nxt = cmprss_otpt_res;
          res_idx_d = '0;
          res_vld_d = 1'b1;
          state_d   = S_OUT;
        end
      end
      S_OUT: begin
        if (res_hs) begin
          res_d_nxt = {res_q[223:0], 32'h0};
          if (res_idx_q == LAST_IDX) begin
            res_vld_d = 1'b0;
            res_idx_d = '0;
            busy_d    = 1'b0;
            cnt_d     = '0;
            state_d   = S_ACC;
          end else begin
            res_idx_d = res_idx_q + 3'd1;
          end
        end
      end
      default: state_d = S_ACC;
    endcase

    res_lst_d = res_vld_d && (res_idx_d == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_ACC;
      run_q     <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      res_q     <= '0;
      res_idx_q <= '0;
      res_vld_q <= 1'b0;
      res_lst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      res_q     <= res_d_nxt;
      res_idx_q <= res_idx_d;
      res_vld_q <= res_vld_d;
      res_lst_q <= res_lst_d;
    end
  end

  assign res_d        = res_q[255:224];
  assign res_vld      = res_vld_q;
  assign res_lst      = res_lst_q;
  assign busy         = busy_q;
  assign msg_byte_cnt = cnt_q;
  assign len_ovf      = ovf_q;

endmodule

// File: tb/tb_sm3_msg_feeder.sv
// Testbench for sm3_msg_feeder: directed and randomized messages against a byte-list model.
`timescale 1ns/1ps
module tb_sm3_msg_feeder;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  be;
    logic        lst;
  } wexp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   byte_d = '0;
  logic         byte_vld = 1'b0, byte_lst = 1'b0;
  logic         msg_inpt_rdy = 1'b0, res_rdy = 1'b0;
  logic [255:0] cmprss_otpt_res = '0;
  logic         cmprss_otpt_vld = 1'b0;

  logic         byte_rdy, msg_inpt_vld, msg_inpt_lst, res_vld, res_lst, busy, len_ovf;
  logic [31:0]  msg_inpt_d, res_d;
  logic [3:0]   msg_inpt_vld_byte;
  logic [15:0]  msg_byte_cnt;

  logic         byte_rdy_4, msg_inpt_vld_4, msg_inpt_lst_4, res_vld_4, res_lst_4, busy_4, len_ovf_4;
  logic [31:0]  msg_inpt_d_4, res_d_4;
  logic [3:0]   msg_inpt_vld_byte_4;
  logic [3:0]   msg_byte_cnt_4;

  int tests = 0, fails = 0;
  int rdy_mode = 1, res_mode = 1;
  logic [7:0] msg_q[$];
  wexp_t      exp_words[$];

  localparam logic [255:0] ABC_DIG =
    256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;

  always #5 clk = ~clk;

  sm3_msg_feeder u_dut (
    .clk(clk), .rst_n(rst_n), .byte_d(byte_d), .byte_vld(byte_vld), .byte_lst(byte_lst),
    .byte_rdy(byte_rdy), .msg_inpt_d(msg_inpt_d), .msg_inpt_vld_byte(msg_inpt_vld_byte),
    .msg_inpt_vld(msg_inpt_vld), .msg_inpt_lst(msg_inpt_lst), .msg_inpt_rdy(msg_inpt_rdy),
    .cmprss_otpt_res(cmprss_otpt_res), .cmprss_otpt_vld(cmprss_otpt_vld),
    .res_d(res_d), .res_vld(res_vld), .res_lst(res_lst), .res_rdy(res_rdy),
    .busy(busy), .msg_byte_cnt(msg_byte_cnt), .len_ovf(len_ovf)
  );

  sm3_msg_feeder #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .byte_d(byte_d), .byte_vld(byte_vld), .byte_lst(byte_lst),
    .byte_rdy(byte_rdy_4), .msg_inpt_d(msg_inpt_d_4), .msg_inpt_vld_byte(msg_inpt_vld_byte_4),
    .msg_inpt_vld(msg_inpt_vld_4), .msg_inpt_lst(msg_inpt_lst_4), .msg_inpt_rdy(msg_inpt_rdy),
    .cmprss_otpt_res(cmprss_otpt_res), .cmprss_otpt_vld(cmprss_otpt_vld),
    .res_d(res_d_4), .res_vld(res_vld_4), .res_lst(res_lst_4), .res_rdy(res_rdy),
    .busy(busy_4), .msg_byte_cnt(msg_byte_cnt_4), .len_ovf(len_ovf_4)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Ready generators: 0 = held low, 1 = held high, 2 = random (core) / toggling (result).
  always @(posedge clk) begin
    #1;
    msg_inpt_rdy = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 1) == 1);
    res_rdy      = (res_mode == 1) || (res_mode == 2 && !res_rdy);
  end

  // Message-word monitor: every handshake must match the next modelled word.
  logic        st_pend = 1'b0;
  logic [31:0] st_d;
  logic [3:0]  st_be;
  logic        st_lst;
  wexp_t       mw;
  always @(negedge clk) begin
    if (!rst_n) st_pend = 1'b0;
    else begin
      if (st_pend) begin
        chk("msg_hold_vld", msg_inpt_vld, 1'b1);
        chk("msg_hold_d", msg_inpt_d, st_d);
        chk("msg_hold_be", msg_inpt_vld_byte, st_be);
        chk("msg_hold_lst", msg_inpt_lst, st_lst);
      end
      if (msg_inpt_vld && msg_inpt_rdy) begin
        if (exp_words.size() == 0) chk("msg_extra_word", msg_inpt_vld, 1'b0);
        else begin
          mw = exp_words.pop_front();
          chk("msg_d", msg_inpt_d, mw.d);
          chk("msg_be", msg_inpt_vld_byte, mw.be);
          chk("msg_lst", msg_inpt_lst, mw.lst);
        end
      end
      st_pend = msg_inpt_vld && !msg_inpt_rdy;
      st_d    = msg_inpt_d;
      st_be   = msg_inpt_vld_byte;
      st_lst  = msg_inpt_lst;
    end
  end

  // Model: split msg_q into 4-byte groups, big-endian, trailing partial only if message ends.
  task automatic model_words(input int n, input bit with_lst);
    int k;
    wexp_t e;
    for (int base = 0; base < n; base += 4) begin
      k = (n - base >= 4) ? 4 : n - base;
      if (k < 4 && !with_lst) break;
      e.d = '0;
      e.be = '0;
      for (int j = 0; j < k; j++) begin
        e.d[31-8*j -: 8] = msg_q[base+j];
        e.be[3-j] = 1'b1;
      end
      e.lst = with_lst && (base + 4 >= n);
      exp_words.push_back(e);
    end
  endtask

  task automatic send_bytes(input int n, input bit with_lst);
    int guard;
    for (int i = 0; i < n; i++) begin
      byte_d   = msg_q[i];
      byte_lst = with_lst && (i == n - 1);
      byte_vld = 1'b1;
      guard = 0;
      forever begin
        @(negedge clk);
        if (byte_rdy) break;
        guard++;
        if (guard > 500) begin
          chk("byte_accept_timeout", byte_rdy, 1'b1);
          break;
        end
      end
      @(posedge clk); #1;
    end
    byte_vld = 1'b0;
    byte_lst = 1'b0;
    byte_d   = '0;
  endtask

  task automatic run_msg(input int n, input logic [255:0] dig);
    int guard, idx;
    logic [31:0] prev_d;
    logic prev_pend;
    chk("busy_idle", busy, 1'b0);
    model_words(n, 1'b1);
    send_bytes(n, 1'b1);
    guard = 0;
    while (exp_words.size() != 0 && guard < 1000) begin
      @(negedge clk); #1;
      guard++;
    end
    chk("msg_drain", exp_words.size(), 0);
    @(posedge clk); #1;
    chk("busy_hash", busy, 1'b1);
    chk("byte_rdy_hash", byte_rdy, 1'b0);
    chk("cnt", msg_byte_cnt, n);
    chk("ovf", len_ovf, 1'b0);
    chk("cnt4", msg_byte_cnt_4, (n > 15) ? 15 : n);
    chk("ovf4", len_ovf_4, n > 15);
    cmprss_otpt_res = dig;
    cmprss_otpt_vld = 1'b1;
    @(posedge clk); #1;
    cmprss_otpt_vld = 1'b0;
    cmprss_otpt_res = '0;
    idx = 0;
    guard = 0;
    prev_pend = 1'b0;
    prev_d = '0;
    while (idx < 8 && guard < 500) begin
      @(negedge clk);
      guard++;
      if (prev_pend) chk("res_hold", res_d, prev_d);
      if (res_vld && res_rdy) begin
        chk("res_d", res_d, dig[255-32*idx -: 32]);
        chk("res_lst", res_lst, idx == 7);
        idx++;
      end
      prev_pend = res_vld && !res_rdy;
      prev_d = res_d;
    end
    chk("res_count", idx, 8);
    @(posedge clk); #1;
    chk("busy_done", busy, 1'b0);
    chk("res_vld_done", res_vld, 1'b0);
    chk("cnt_clr", msg_byte_cnt, 0);
  endtask

  task automatic load_abc();
    msg_q = {8'h61, 8'h62, 8'h63};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    logic [255:0] dig;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_byte_rdy", byte_rdy, 1'b0);
    chk("rst_msg_vld", msg_inpt_vld, 1'b0);
    chk("rst_res_vld", res_vld, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cnt", msg_byte_cnt, 0);
    rst_n = 1'b1;

    // "abc", ready always high
    load_abc();
    run_msg(3, ABC_DIG);

    // 64 bytes "abcd" x16
    msg_q.delete();
    for (int i = 0; i < 64; i++) msg_q.push_back(8'h61 + 8'(i % 4));
    run_msg(64, {8{32'h0badf00d}} ^ {$urandom, $urandom, $urandom, $urandom,
                                     $urandom, $urandom, $urandom, $urandom});

    // 5 bytes with the core stalled on the first word
    msg_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    rdy_mode = 0;
    fork
      run_msg(5, ABC_DIG);
      begin
        g = 0;
        while (!msg_inpt_vld && g < 200) begin @(negedge clk); g++; end
        repeat (5) @(negedge clk);
        chk("stall_byte_rdy", byte_rdy, 1'b0);
        chk("stall_cnt", msg_byte_cnt, 5);
        chk("stall_word", msg_inpt_d, 32'h01020304);
        @(posedge clk); #1;
        rdy_mode = 1;
      end
    join

    // stray digest pulse while idle must be ignored
    cmprss_otpt_vld = 1'b1;
    cmprss_otpt_res = {8{32'hdeadbeef}};
    @(posedge clk); #1;
    cmprss_otpt_vld = 1'b0;
    cmprss_otpt_res = '0;
    for (int i = 0; i < 3; i++) begin
      chk("stray_res_vld", res_vld, 1'b0);
      @(posedge clk); #1;
    end

    // result backpressure toggling, random core ready, random digest
    res_mode = 2;
    rdy_mode = 2;
    msg_q.delete();
    for (int i = 0; i < 11; i++) msg_q.push_back(8'($urandom));
    dig = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_msg(11, dig);
    res_mode = 1;
    rdy_mode = 1;

    // reset in the middle of a 6-byte message
    msg_q = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    model_words(6, 1'b0);
    send_bytes(6, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_msg_vld", msg_inpt_vld, 1'b0);
    chk("mid_rst_msg_d", msg_inpt_d, 0);
    chk("mid_rst_msg_be", msg_inpt_vld_byte, 0);
    chk("mid_rst_msg_lst", msg_inpt_lst, 1'b0);
    chk("mid_rst_byte_rdy", byte_rdy, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_cnt", msg_byte_cnt, 0);
    chk("mid_rst_res_d", res_d, 0);
    chk("mid_rst_cnt4", msg_byte_cnt_4, 0);
    chk("mid_rst_queue", exp_words.size(), 0);
    exp_words.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    load_abc();
    run_msg(3, ABC_DIG);

    // 17 bytes: 4-bit counter saturates
    msg_q.delete();
    for (int i = 1; i <= 17; i++) msg_q.push_back(8'(i));
    run_msg(17, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});

    // random messages with random handshakes
    rdy_mode = 2;
    res_mode = 2;
    for (int m = 0; m < 4; m++) begin
      int n;
      n = $urandom_range(1, 40);
      msg_q.delete();
      for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
      dig = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_msg(n, dig);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
